// File: rtl/dac_pulse_pkg.sv
// dac_pulse_pkg
// Shared definitions for the DAC pulse sequencer slice.
//   SAMPLE_W   : width of signed ADC/DAC samples (16)
//   COUNT_W    : width of unsigned cycle counts and the fire counter (16)
//   COUNT_MAX  : saturation ceiling of the fire counter
//   state_t    : sequencer state encoding as seen on the State output
//   atLeastOne : clamps a zero cycle count up to one cycle
package dac_pulse_pkg;

  localparam int SAMPLE_W = 16;
  localparam int COUNT_W  = 16;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // The numeric values are visible to software through the State port,
  // so they are pinned explicitly rather than left to enum defaults.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FIRING   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  // A programmed length of zero still yields a one-cycle phase, so every
  // place that loads a down-counter goes through this clamp.
  function automatic logic [COUNT_W-1:0] atLeastOne(input logic [COUNT_W-1:0] value);
    return (value == '0) ? COUNT_W'(1) : value;
  endfunction

endpackage

// File: rtl/threshold_crossing_det.sv
// threshold_crossing_det
// Registers the incoming ADC stream and flags an upward threshold crossing.
//   i_clk       : sole clock, rising edge
//   i_rst       : asynchronous active-high reset, clears both sample registers
//   i_sample    : signed ADC sample, captured every cycle
//   i_threshold : signed crossing threshold
//   o_crossing  : high while the previous sample is below the threshold and
//                 the current sample is at or above it
module threshold_crossing_det
  import dac_pulse_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [SAMPLE_W-1:0] i_threshold,
  output logic                       o_crossing
);

  logic signed [SAMPLE_W-1:0] r_s;
  logic signed [SAMPLE_W-1:0] r_sPrev;

  // Two-deep sample history: r_s is the sample captured at the most recent
  // edge and r_sPrev the one before it. Both clear to zero so that a
  // positive threshold cannot see a spurious crossing straight out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s     <= '0;
      r_sPrev <= '0;
    end else begin
      r_s     <= i_sample;
      r_sPrev <= r_s;
    end
  end

  // The crossing is decoded from registered samples only, so it is valid for
  // the whole cycle after the crossing sample is captured. The sequencer acts
  // on it at the following edge, which gives the one-edge output latency.
  assign o_crossing = (r_sPrev < i_threshold) && (r_s >= i_threshold);

endmodule

// File: rtl/dac_pulse_sequencer.sv
// dac_pulse_sequencer
// Watches an ADC stream for an upward threshold crossing and answers it with
// a fixed-amplitude DAC pulse followed by a dead-time window.
//   i_clk            : sole clock, rising edge
//   i_rst            : asynchronous active-high reset
//   i_enable         : level; low forces IDLE and a zero output
//   i_arm            : level; a rising edge arms the block from IDLE
//   i_autoRearm      : when high, the block re-arms itself after cooldown
//   i_clearCount     : single-cycle pulse clearing the fire counter
//   i_inputA         : signed ADC sample stream
//   i_trigThreshold  : signed upward-crossing threshold
//   i_pulseAmplitude : signed DAC level during the pulse
//   i_pulseWidth     : pulse length in cycles (0 behaves as 1)
//   i_cooldownCycles : dead time after the pulse in cycles (0 behaves as 1)
//   o_outputA        : registered signed DAC sample
//   o_state          : IDLE=0, ARMED=1, FIRING=2, COOLDOWN=3
//   o_fireCount      : saturating count of pulses fired
module dac_pulse_sequencer
  import dac_pulse_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic                       i_arm,
  input  logic                       i_autoRearm,
  input  logic                       i_clearCount,
  input  logic signed [SAMPLE_W-1:0] i_inputA,
  input  logic signed [SAMPLE_W-1:0] i_trigThreshold,
  input  logic signed [SAMPLE_W-1:0] i_pulseAmplitude,
  input  logic        [COUNT_W-1:0]  i_pulseWidth,
  input  logic        [COUNT_W-1:0]  i_cooldownCycles,
  output logic signed [SAMPLE_W-1:0] o_outputA,
  output logic        [1:0]          o_state,
  output logic        [COUNT_W-1:0]  o_fireCount
);

  state_t                     r_state;
  state_t                     w_stateNext;
  logic        [COUNT_W-1:0]  r_counter;
  logic        [COUNT_W-1:0]  w_counterNext;
  logic signed [SAMPLE_W-1:0] r_amplitude;
  logic signed [SAMPLE_W-1:0] w_amplitudeNext;
  logic signed [SAMPLE_W-1:0] r_outputA;
  logic signed [SAMPLE_W-1:0] w_outputANext;
  logic        [COUNT_W-1:0]  r_fireCount;
  logic        [COUNT_W-1:0]  w_fireCountNext;
  logic                       r_armPrev;
  logic                       w_armRise;
  logic                       w_crossing;
  logic                       w_fireEntry;

  threshold_crossing_det u_crossingDet (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sample    (i_inputA),
    .i_threshold (i_trigThreshold),
    .o_crossing  (w_crossing)
  );

  // Arm is a level from a control register; only its rising edge means
  // "arm now". The history bit resets to one so that an Arm already high
  // when reset lifts is not mistaken for a fresh command.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_armPrev <= 1'b1;
    end else begin
      r_armPrev <= i_arm;
    end
  end

  assign w_armRise = i_arm & ~r_armPrev;

  // State register plus everything that moves with it: the shared phase
  // down-counter, the latched pulse amplitude, the DAC output register and
  // the fire counter. The output register has an async reset so a reset in
  // the middle of a pulse silences the DAC without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_counter   <= '0;
      r_amplitude <= '0;
      r_outputA   <= '0;
      r_fireCount <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_counter   <= w_counterNext;
      r_amplitude <= w_amplitudeNext;
      r_outputA   <= w_outputANext;
      r_fireCount <= w_fireCountNext;
    end
  end

  // Next-state and next-output decode. One down-counter serves both timed
  // phases: it is loaded with the clamped pulse width on entry to FIRING and
  // with the clamped cooldown length on entry to COOLDOWN, and each phase
  // ends on the cycle the counter reads one. Width and amplitude are sampled
  // only at the firing edge and cooldown length only at the cooldown edge,
  // so register writes during a pulse cannot stretch or reshape it.
  // Crossings are looked at only in ARMED; anywhere else they are dropped.
  // Enable low overrides every other transition.
  always_comb begin
    w_stateNext     = r_state;
    w_counterNext   = r_counter;
    w_amplitudeNext = r_amplitude;
    w_outputANext   = '0;
    w_fireEntry     = 1'b0;

    if (!i_enable) begin
      w_stateNext   = ST_IDLE;
      w_counterNext = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_armRise) begin
            w_stateNext = ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (w_crossing) begin
            w_stateNext     = ST_FIRING;
            w_counterNext   = atLeastOne(i_pulseWidth);
            w_amplitudeNext = i_pulseAmplitude;
            w_outputANext   = i_pulseAmplitude;
            w_fireEntry     = 1'b1;
          end
        end

        ST_FIRING: begin
          if (r_counter <= COUNT_W'(1)) begin
            w_stateNext   = ST_COOLDOWN;
            w_counterNext = atLeastOne(i_cooldownCycles);
          end else begin
            w_counterNext = r_counter - COUNT_W'(1);
            w_outputANext = r_amplitude;
          end
        end

        ST_COOLDOWN: begin
          if (r_counter <= COUNT_W'(1)) begin
            w_stateNext   = i_autoRearm ? ST_ARMED : ST_IDLE;
            w_counterNext = '0;
          end else begin
            w_counterNext = r_counter - COUNT_W'(1);
          end
        end

        default: begin
          w_stateNext   = ST_IDLE;
          w_counterNext = '0;
        end
      endcase
    end
  end

  // Fire counter update. A pulse entry wins over a plain clear, but when the
  // two coincide the clear still wipes the old total and the new pulse is
  // counted on top of it, giving one. The counter sticks at its ceiling
  // instead of wrapping so software never sees a small number after many
  // pulses.
  always_comb begin
    w_fireCountNext = r_fireCount;
    if (w_fireEntry) begin
      if (i_clearCount) begin
        w_fireCountNext = COUNT_W'(1);
      end else if (r_fireCount != COUNT_MAX) begin
        w_fireCountNext = r_fireCount + COUNT_W'(1);
      end
    end else if (i_clearCount) begin
      w_fireCountNext = '0;
    end
  end

  assign o_outputA   = r_outputA;
  assign o_state     = r_state;
  assign o_fireCount = r_fireCount;

endmodule

// File: tb/tb_dac_pulse_sequencer.sv
// tb_dac_pulse_sequencer
// Self-checking bench for dac_pulse_sequencer: directed scenarios for the
// basic pulse, auto re-arm, ignored crossings, enable abort, async reset,
// arm-through-reset and counter saturation, then a randomized run checked
// against a pulse-window model built from the crossing times.
module tb_dac_pulse_sequencer;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               arm;
  logic               autoRearm;
  logic               clearCount;
  logic signed [15:0] inputA;
  logic signed [15:0] trigThreshold;
  logic signed [15:0] pulseAmplitude;
  logic        [15:0] pulseWidth;
  logic        [15:0] cooldownCycles;
  logic signed [15:0] outputA;
  logic        [1:0]  state;
  logic        [15:0] fireCount;

  int errors = 0;
  int checks = 0;

  localparam int RAND_N = 240;
  localparam int QUIET  = 30;

  dac_pulse_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .i_arm            (arm),
    .i_autoRearm      (autoRearm),
    .i_clearCount     (clearCount),
    .i_inputA         (inputA),
    .i_trigThreshold  (trigThreshold),
    .i_pulseAmplitude (pulseAmplitude),
    .i_pulseWidth     (pulseWidth),
    .i_cooldownCycles (cooldownCycles),
    .o_outputA        (outputA),
    .o_state          (state),
    .o_fireCount      (fireCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, program the pulse parameters, then produce an Arm rising edge so
  // the block sits in ARMED with sample history of 50 (below threshold 100).
  task automatic setupArmed(input logic autoRe, input logic [15:0] pw,
                            input logic [15:0] cd, input logic [15:0] amp);
    rst            = 1'b1;
    enable         = 1'b1;
    arm            = 1'b0;
    autoRearm      = autoRe;
    clearCount     = 1'b0;
    inputA         = 16'sd50;
    trigThreshold  = 16'sd100;
    pulseAmplitude = amp;
    pulseWidth     = pw;
    cooldownCycles = cd;
    tick();
    rst = 1'b0;
    tick();
    arm = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1; arm = 1'b0; autoRearm = 1'b0; clearCount = 1'b0;
    inputA = '0; trigThreshold = 16'sd100; pulseAmplitude = 16'h4000;
    pulseWidth = 16'd4; cooldownCycles = 16'd3;
    tick();
    if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
    checks++;
    if (outputA !== 16'sd0) begin errors++; $display("[TB] FAIL reset_out got %h want 0000", outputA); end
    checks++;
    if (fireCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", fireCount); end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_basic_pulse();
    setupArmed(1'b0, 16'd4, 16'd3, 16'h4000);
    if (state !== 2'd1) begin errors++; $display("[TB] FAIL basic_armed got %0d want 1", state); end
    checks++;
    inputA = 16'sd50;  tick();
    inputA = 16'sd150; tick();
    if (outputA !== 16'sd0) begin errors++; $display("[TB] FAIL basic_latency got %h want 0000", outputA); end
    checks++;
    for (int c = 1; c <= 4; c++) begin
      tick();
      // Reprogramming mid-pulse must not alter the pulse already running.
      pulseWidth = 16'd1;
      pulseAmplitude = 16'h1234;
      if (outputA !== 16'sh4000 || state !== 2'd2) begin
        errors++; $display("[TB] FAIL basic_pulse cyc %0d got out=%h st=%0d want out=4000 st=2", c, outputA, state);
      end
      checks++;
    end
    if (fireCount !== 16'd1) begin errors++; $display("[TB] FAIL basic_count got %0d want 1", fireCount); end
    checks++;
    for (int c = 1; c <= 3; c++) begin
      tick();
      cooldownCycles = 16'd9;
      if (outputA !== 16'sd0 || state !== 2'd3) begin
        errors++; $display("[TB] FAIL basic_cool cyc %0d got out=%h st=%0d want out=0000 st=3", c, outputA, state);
      end
      checks++;
    end
    tick();
    if (state !== 2'd0 || outputA !== 16'sd0) begin
      errors++; $display("[TB] FAIL basic_end got st=%0d out=%h want st=0 out=0000", state, outputA);
    end
    checks++;
  endtask

  task automatic test_autorearm();
    logic signed [15:0] expOut;
    logic [1:0]         expSt;
    setupArmed(1'b1, 16'd0, 16'd3, 16'h2345);
    for (int i = 0; i < 20; i++) begin
      inputA = (i == 2 || i == 12) ? 16'sd150 : 16'sd50;
      tick();
      expOut = (i == 3 || i == 13) ? 16'sh2345 : 16'sd0;
      if (i == 3 || i == 13) expSt = 2'd2;
      else if ((i >= 4 && i <= 6) || (i >= 14 && i <= 16)) expSt = 2'd3;
      else expSt = 2'd1;
      if (outputA !== expOut || state !== expSt) begin
        errors++; $display("[TB] FAIL rearm cyc %0d got out=%h st=%0d want out=%h st=%0d", i, outputA, state, expOut, expSt);
      end
      checks++;
    end
    if (fireCount !== 16'd2) begin errors++; $display("[TB] FAIL rearm_count got %0d want 2", fireCount); end
    checks++;
  endtask

  task automatic test_crossing_during_firing();
    logic signed [15:0] expOut;
    logic [1:0]         expSt;
    setupArmed(1'b0, 16'd8, 16'd2, 16'h7000);
    for (int i = 0; i < 14; i++) begin
      inputA = (i == 1 || i >= 3) ? 16'sd150 : 16'sd50;
      tick();
      expOut = (i >= 2 && i <= 9) ? 16'sh7000 : 16'sd0;
      if (i <= 1) expSt = 2'd1;
      else if (i <= 9) expSt = 2'd2;
      else if (i <= 11) expSt = 2'd3;
      else expSt = 2'd0;
      if (outputA !== expOut || state !== expSt) begin
        errors++; $display("[TB] FAIL ignore_cross cyc %0d got out=%h st=%0d want out=%h st=%0d", i, outputA, state, expOut, expSt);
      end
      checks++;
    end
    if (fireCount !== 16'd1) begin errors++; $display("[TB] FAIL ignore_count got %0d want 1", fireCount); end
    checks++;
  endtask

  task automatic test_enable_abort();
    setupArmed(1'b0, 16'd10, 16'd2, 16'h0F0F);
    inputA = 16'sd50;  tick();
    inputA = 16'sd150; tick();
    tick(); tick();
    if (outputA !== 16'sh0F0F) begin errors++; $display("[TB] FAIL abort_pre got %h want 0f0f", outputA); end
    checks++;
    enable = 1'b0;
    tick();
    if (outputA !== 16'sd0 || state !== 2'd0) begin
      errors++; $display("[TB] FAIL abort got out=%h st=%0d want out=0000 st=0", outputA, state);
    end
    checks++;
    enable = 1'b1;
    tick(); tick();
    if (state !== 2'd0) begin errors++; $display("[TB] FAIL abort_stay got %0d want 0", state); end
    checks++;
  endtask

  task automatic test_async_reset();
    setupArmed(1'b0, 16'd10, 16'd2, 16'h3333);
    inputA = 16'sd50;  tick();
    inputA = 16'sd150; tick();
    tick(); tick();
    if (outputA !== 16'sh3333) begin errors++; $display("[TB] FAIL async_pre got %h want 3333", outputA); end
    checks++;
    rst = 1'b1;
    #2;
    if (outputA !== 16'sd0 || state !== 2'd0 || fireCount !== 16'd0) begin
      errors++; $display("[TB] FAIL async_rst got out=%h st=%0d cnt=%0d want 0 0 0", outputA, state, fireCount);
    end
    checks++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_arm_through_reset();
    rst = 1'b1; arm = 1'b1; enable = 1'b1; autoRearm = 1'b0; inputA = 16'sd50;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (state !== 2'd0) begin errors++; $display("[TB] FAIL armrst_hold cyc %0d got %0d want 0", i, state); end
      checks++;
    end
    arm = 1'b0; tick();
    if (state !== 2'd0) begin errors++; $display("[TB] FAIL armrst_low got %0d want 0", state); end
    checks++;
    arm = 1'b1; tick();
    if (state !== 2'd1) begin errors++; $display("[TB] FAIL armrst_rise got %0d want 1", state); end
    checks++;
  endtask

  task automatic test_saturation();
    int expCnt;
    setupArmed(1'b1, 16'd0, 16'd0, 16'h1111);
    // Jump the counter close to its ceiling rather than firing 65 thousand pulses.
    force dut.r_fireCount = 16'hFFFD;
    tick();
    release dut.r_fireCount;
    expCnt = 'hFFFD;
    for (int n = 1; n <= 3; n++) begin
      inputA = 16'sd50;  tick();
      inputA = 16'sd150; tick();
      tick();
      expCnt = (expCnt + 1 > 'hFFFF) ? 'hFFFF : expCnt + 1;
      if (fireCount !== 16'(expCnt)) begin
        errors++; $display("[TB] FAIL sat_count fire %0d got %h want %h", n, fireCount, 16'(expCnt));
      end
      checks++;
      tick(); tick();
    end
    inputA = 16'sd50;  tick();
    inputA = 16'sd150; tick();
    clearCount = 1'b1; tick(); clearCount = 1'b0;
    if (fireCount !== 16'd1) begin errors++; $display("[TB] FAIL clear_fire got %0d want 1", fireCount); end
    checks++;
    tick(); tick();
    clearCount = 1'b1; tick(); clearCount = 1'b0;
    if (fireCount !== 16'd0) begin errors++; $display("[TB] FAIL clear_only got %0d want 0", fireCount); end
    checks++;
  endtask

  // Random run with auto re-arm. The model works on crossing times: a
  // crossing captured at edge k is accepted only when the block is armed
  // after edge k, and then owns edges k+1..k+W as the pulse and the next C
  // edges as dead time, with W and C taken from the values presented at the
  // entry edges of those phases.
  task automatic test_random();
    int smp[RAND_N];
    logic [15:0] pwA[RAND_N];
    logic [15:0] cdA[RAND_N];
    logic [15:0] ampA[RAND_N];
    int expSt[RAND_N];
    logic [15:0] expOut[RAND_N];
    int fires[RAND_N];
    int ready, prev, w, c, total;

    for (int i = 0; i < RAND_N; i++) begin
      smp[i]  = (i >= RAND_N - QUIET) ? 0 : 60 + int'($urandom_range(0, 80));
      pwA[i]  = 16'($urandom_range(0, 6));
      cdA[i]  = 16'($urandom_range(0, 5));
      ampA[i] = 16'($urandom);
      expSt[i] = 1;
      expOut[i] = '0;
      fires[i] = 0;
    end
    ready = 0;
    for (int k = 0; k < RAND_N - 1; k++) begin
      prev = (k == 0) ? 50 : smp[k-1];
      if (prev < 100 && smp[k] >= 100 && k >= ready) begin
        w = (pwA[k+1] == 16'd0) ? 1 : int'(pwA[k+1]);
        c = (cdA[k+w+1] == 16'd0) ? 1 : int'(cdA[k+w+1]);
        for (int e = k + 1; e <= k + w; e++) begin expSt[e] = 2; expOut[e] = ampA[k+1]; end
        for (int e = k + w + 1; e <= k + w + c; e++) expSt[e] = 3;
        fires[k+1] = 1;
        ready = k + w + c + 1;
      end
    end

    setupArmed(1'b1, 16'd1, 16'd1, 16'h0001);
    total = 0;
    for (int i = 0; i < RAND_N; i++) begin
      inputA = 16'(smp[i]);
      pulseWidth = pwA[i];
      cooldownCycles = cdA[i];
      pulseAmplitude = ampA[i];
      tick();
      total += fires[i];
      if (outputA !== expOut[i] || state !== 2'(expSt[i]) || fireCount !== 16'(total)) begin
        errors++;
        $display("[TB] FAIL random cyc %0d got out=%h st=%0d cnt=%0d want out=%h st=%0d cnt=%0d",
                 i, outputA, state, fireCount, expOut[i], expSt[i], total);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_pulse();
    test_autorearm();
    test_crossing_during_firing();
    test_enable_abort();
    test_async_reset();
    test_arm_through_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
